// File: rtl/aes_pkg.sv
// Shared AES helpers for the forward cipher core: byte ordering, round
// constants, GF(2^8) arithmetic, ShiftRows, MixColumns and the FSM states.
package aes_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_state_t;

    localparam int NR = 10;

    // Byte k of a 128-bit state lives at [127-8k -: 8]; column c is bytes
    // 4c..4c+3 and row r is k mod 4.
    function automatic logic [7:0] get_byte(input logic [127:0] s, input int k);
        return s[127-8*k -: 8];
    endfunction

    function automatic logic [7:0] rcon_of(input logic [3:0] rnd);
        logic [7:0] r;
        case (rnd)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Multiply by x modulo the AES polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    // Forward ShiftRows: out(row r, col c) = in(row r, col (c+r) mod 4).
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = get_byte(s, 4*((c+r)%4)+r);
            end
        end
        return o;
    endfunction

    // MixColumns with matrix rows {02 03 01 01} and rotations, per column.
    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = get_byte(s, 4*c);
            a1 = get_byte(s, 4*c+1);
            a2 = get_byte(s, 4*c+2);
            a3 = get_byte(s, 4*c+3);
            o[127-8*(4*c)   -: 8] = gf_mul2(a0) ^ gf_mul3(a1) ^ a2 ^ a3;
            o[127-8*(4*c+1) -: 8] = a0 ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3;
            o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gf_mul2(a2) ^ gf_mul3(a3);
            o[127-8*(4*c+3) -: 8] = gf_mul3(a0) ^ a1 ^ a2 ^ gf_mul2(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte in, one byte out.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    // Entry n of the table sits at [2047-8n -: 8].
    localparam logic [2047:0] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Table lookup indexed by the input byte.
    always_comb begin
        y = SBOX_TAB[(11'd2047 - {a, 3'b000}) -: 8];
    end

endmodule

// File: rtl/aes128_enc_core.sv
// Iterative AES-128 encryption core: initial AddRoundKey on the start
// cycle, then one round per clock with the key schedule expanded alongside.
//
// Handshake: start is honoured only while busy = 0; key and pt are sampled
// on that cycle alone. busy stays high for the ten round cycles, and done
// pulses for one cycle together with the new ct. A start in the done cycle
// is accepted, so blocks can be issued back to back every 11 cycles.
module aes128_enc_core
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] pt,
    output logic         busy,
    output logic         done,
    output logic [127:0] ct
);

    fsm_state_t   state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] ct_q, ct_d;
    logic         done_q, done_d;

    logic [127:0] sub_bytes;
    logic [127:0] shifted;
    logic [127:0] mixed;
    logic [31:0]  rot_w3;
    logic [31:0]  sub_rot;
    logic [31:0]  w0n, w1n, w2n, w3n;
    logic [127:0] rk_next;

    // SubBytes on the running state: one S-box per byte.
    for (genvar i = 0; i < 16; i++) begin : g_sb
        aes_sbox u_sbox (
            .a (blk_q[127-8*i -: 8]),
            .y (sub_bytes[127-8*i -: 8])
        );
    end

    assign rot_w3 = {rk_q[23:0], rk_q[31:24]};

    // SubWord(RotWord(w3)) for the key schedule.
    for (genvar j = 0; j < 4; j++) begin : g_kw
        aes_sbox u_sbox (
            .a (rot_w3[31-8*j -: 8]),
            .y (sub_rot[31-8*j -: 8])
        );
    end

    // Round datapath and next round key.
    always_comb begin
        shifted = shift_rows(sub_bytes);
        mixed   = mix_columns(shifted);
        w0n     = rk_q[127:96] ^ sub_rot ^ {rcon_of(round_q), 24'h0};
        w1n     = rk_q[95:64] ^ w0n;
        w2n     = rk_q[63:32] ^ w1n;
        w3n     = rk_q[31:0]  ^ w2n;
        rk_next = {w0n, w1n, w2n, w3n};
    end

    // Next-state logic: accept in IDLE, iterate rounds in RUN.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        blk_d   = blk_q;
        rk_d    = rk_q;
        ct_d    = ct_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    blk_d   = pt ^ key;
                    rk_d    = key;
                    round_d = 4'd1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (round_q >= 4'd1 && round_q < 4'd10) begin
                    blk_d   = mixed ^ rk_next;
                    rk_d    = rk_next;
                    round_d = round_q + 4'd1;
                end else if (round_q == 4'd10) begin
                    ct_d    = shifted ^ rk_next;
                    done_d  = 1'b1;
                    round_d = 4'd0;
                    state_d = IDLE;
                end else begin
                    // Unreachable counter value: abandon the block silently.
                    round_d = 4'd0;
                    state_d = IDLE;
                end
            end
            default: begin
                round_d = 4'd0;
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            round_q <= 4'd0;
            blk_q   <= '0;
            rk_q    <= '0;
            ct_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            blk_q   <= blk_d;
            rk_q    <= rk_d;
            ct_q    <= ct_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign ct   = ct_q;

endmodule

// File: tb/tb_aes128_enc_core.sv
// Bench for aes128_enc_core: FIPS-197 vectors, back-to-back issue, ignored
// start while busy, and reset in the middle of a block.
module tb_aes128_enc_core;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key;
    logic [127:0] pt;
    logic         busy;
    logic         done;
    logic [127:0] ct;

    aes128_enc_core dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .key   (key),
        .pt    (pt),
        .busy  (busy),
        .done  (done),
        .ct    (ct)
    );

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_R1   = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   cyc = 0;
    logic rst_at_edge = 1'b0;
    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [127:0] exp_q[$];
    int           exp_cyc_q[$];
    logic [127:0] ct_prev;
    logic         mon_en = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done, and checks ct holds otherwise.
    always @(negedge clk) begin
        if (mon_en) begin
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
                end else begin
                    check("done_ct", ct, exp_q.pop_front());
                    check("done_cycle", 128'(cyc), 128'(exp_cyc_q.pop_front()));
                end
            end else if (!rst_at_edge) begin
                check("ct_hold", ct, ct_prev);
            end
        end
        ct_prev = ct;
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_start(input logic [127:0] k, input logic [127:0] p,
                               input logic [127:0] exp, input bit push);
        start = 1'b1;
        key   = k;
        pt    = p;
        if (push) begin
            exp_q.push_back(exp);
            exp_cyc_q.push_back(cyc + 11);
        end
        tick();
        start = 1'b0;
        key   = {$urandom(), $urandom(), $urandom(), $urandom()};
        pt    = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL timeout: got %0d pending results expected 0", exp_q.size());
            exp_q.delete();
            exp_cyc_q.delete();
        end
        tick();
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        key   = '0;
        pt    = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_ct", ct, 128'h0);
        rst = 1'b0;
        tick();
        mon_en = 1'b1;

        // FIPS-197 C.1 with busy profile over cycles 1..11
        issue_start(C1_KEY, C1_PT, C1_CT, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check("busy_run", 128'(busy), 128'd1);
            tick();
        end
        @(negedge clk);
        check("busy_end", 128'(busy), 128'd0);
        wait_idle();

        // FIPS-197 Appendix B, with state after round 1 inspected
        issue_start(B_KEY, B_PT, B_CT, 1'b1);
        tick();
        @(negedge clk);
        check("b_round1_state", dut.blk_q, B_R1);
        wait_idle();

        // All-zero key and plaintext
        issue_start(128'h0, 128'h0, Z_CT, 1'b1);
        wait_idle();

        // Back-to-back with an ignored start in cycle 5
        issue_start(C1_KEY, C1_PT, C1_CT, 1'b1);
        repeat (4) tick();
        start = 1'b1;
        key   = {$urandom(), $urandom(), $urandom(), $urandom()};
        pt    = {$urandom(), $urandom(), $urandom(), $urandom()};
        tick();
        start = 1'b0;
        repeat (5) tick();
        issue_start(B_KEY, B_PT, B_CT, 1'b1);
        wait_idle();

        // Reset in cycle 6 of a block: no done for it, then a clean block
        issue_start(C1_KEY, C1_PT, C1_CT, 1'b0);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_done", 128'(done), 128'd0);
        check("abort_ct", ct, 128'h0);
        rst = 1'b0;
        repeat (15) tick();
        issue_start(B_KEY, B_PT, B_CT, 1'b1);
        wait_idle();

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
